// File: rtl/btn_pkg.sv
// Shared types and default constants for the debounced button scanner.
package btn_pkg;

   localparam int DEF_NUM_BTN       = 4;
   localparam int DEF_DEBOUNCE_TIME = 1250000;
   localparam int DEF_FIFO_DEPTH    = 4;

   // Wide enough to index the largest supported button count (8).
   localparam int BTN_IDX_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [BTN_IDX_W-1:0] btn;
      logic                 press;
   } evt_t;

endpackage

// File: rtl/btn_evt_fifo.sv
// Small event queue. A push while full is still accepted when a pop happens
// in the same cycle; otherwise it is dropped and drop_o pulses.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module btn_evt_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign drop_o  = push_i && full_o && !pop_ok;

   // Head is read straight from registered storage; forced to zero when empty.
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Occupancy next-state from the accepted push/pop pair.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/button_scan_arbiter.sv
// Debounces NUM_BTN raw active-low buttons with a single shared counter,
// granting buttons round-robin, and queues press/release events.
module button_scan_arbiter
   import btn_pkg::*;
#(
   parameter int NUM_BTN       = DEF_NUM_BTN,
   parameter int DEBOUNCE_TIME = DEF_DEBOUNCE_TIME,
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_BTN-1:0]         btn_in,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(NUM_BTN)-1:0] evt_btn,
   output logic                       evt_press,
   output logic [NUM_BTN-1:0]         btn_level,
   output logic                       busy,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int IDX_W = $clog2(NUM_BTN);
   localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

   logic [NUM_BTN-1:0] s1_q, s2_q;
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] cand;
   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   grant_q, last_grant_q;
   logic [IDX_W:0]     pick;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               overflow_q, overflow_d;
   logic               push, pop, drop;
   logic               fifo_full, fifo_empty;
   evt_t               push_evt, head_evt;

   // Round-robin scan starting just after the last served button.
   // Returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_BTN-1:0] c,
                                              input logic [IDX_W-1:0]   last);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               pos;
      found = 1'b0;
      idx   = '0;
      for (int off = 1; off <= NUM_BTN; off++) begin
         pos = (int'(last) + off) % NUM_BTN;
         if (!found && c[pos]) begin
            found = 1'b1;
            idx   = IDX_W'(pos);
         end
      end
      return {found, idx};
   endfunction

   // Two-flop synchroniser; idle level of an active-low button is 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   assign cand       = s2_q ^ level_q;
   assign pick       = rr_pick(cand, last_grant_q);
   assign pick_found = pick[IDX_W];
   assign pick_idx   = pick[IDX_W-1:0];

   // Scan / debounce / commit sequencer sharing one counter across buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_BTN - 1);
         level_q      <= '1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_q <= pick_idx;
                  cnt_q   <= '0;
                  state_q <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (s2_q[grant_q] == level_q[grant_q]) begin
                  // Bounced back before the debounce window elapsed.
                  cnt_q        <= '0;
                  last_grant_q <= grant_q;
                  state_q      <= ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_COMMIT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_COMMIT: begin
               level_q[grant_q] <= s2_q[grant_q];
               last_grant_q     <= grant_q;
               state_q          <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign push = (state_q == ST_COMMIT);
   assign pop  = evt_valid && evt_ready;

   // Event record for the button being committed; falling level is a press.
   always_comb begin
      push_evt       = '0;
      push_evt.btn   = BTN_IDX_W'(grant_q);
      push_evt.press = ~s2_q[grant_q];
   end

   btn_evt_fifo #(
      .WIDTH ($bits(evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_evt),
      .pop_i       (pop),
      .pop_data_o  (head_evt),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .drop_o      (drop)
   );

   // A drop in the same cycle as a clear wins, so no loss goes unreported.
   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   // Sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign evt_valid = !fifo_empty;
   assign evt_btn   = IDX_W'(head_evt.btn);
   assign evt_press = head_evt.press;
   assign btn_level = level_q;
   assign busy      = (state_q != ST_IDLE);
   assign overflow  = overflow_q;

   // Full status is implied by drop; kept visible for debug probes.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule
